// File: rtl/aq_gemac_tx_frame_buff_if.sv
// TX frame buffer bus: word write side with back-pressure,
// plus the byte stream and status toward the MAC.
interface aq_gemac_tx_frame_buff_if #(
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 8
);
  logic              TX_BUFF_WE;
  logic              TX_BUFF_START;
  logic              TX_BUFF_END;
  logic [31:0]       TX_BUFF_DATA;
  logic              TX_BUFF_READY;
  logic              TX_BUFF_FULL;
  logic [ADDR_W:0]   TX_BUFF_SPACE;
  logic              TXB_VALID;
  logic [7:0]        TXB_DATA;
  logic              TXB_FIRST;
  logic              TXB_LAST;
  logic              TXB_READY;
  logic [CNT_W-1:0]  FRAME_COUNT;
  logic              DROP;

  modport master (
    output TX_BUFF_WE, TX_BUFF_START, TX_BUFF_END,
    output TX_BUFF_DATA, TXB_READY,
    input  TX_BUFF_READY, TX_BUFF_FULL, TX_BUFF_SPACE,
    input  TXB_VALID, TXB_DATA, TXB_FIRST, TXB_LAST,
    input  FRAME_COUNT, DROP
  );

  modport slave (
    input  TX_BUFF_WE, TX_BUFF_START, TX_BUFF_END,
    input  TX_BUFF_DATA, TXB_READY,
    output TX_BUFF_READY, TX_BUFF_FULL, TX_BUFF_SPACE,
    output TXB_VALID, TXB_DATA, TXB_FIRST, TXB_LAST,
    output FRAME_COUNT, DROP
  );
endinterface

// File: rtl/aq_gemac_tx_frame_buff.sv
// Frame-committing TX word buffer; frames become visible
// only after END and are replayed to the MAC byte by byte.
module aq_gemac_tx_frame_buff #(
  parameter int ADDR_W    = 9,
  parameter int MIN_SPACE = 384,
  parameter int CNT_W     = 8
) (
  input logic CLK,
  input logic RST,
  aq_gemac_tx_frame_buff_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = ADDR_W + 1;
  localparam logic [15:0] MAX_L = 16'(4 * (DEPTH - 1));

  typedef enum logic {WIDLE, WFRAME} wst_t;
  typedef enum logic [1:0] {RIDLE, RHDR, RDATA} rdst_t;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdq;

  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr;
  logic [PW-1:0] used, space;
  logic          full;

  wst_t        wst, wst_n;
  logic [15:0] len, wcnt, wcnt_p1, need, in_len;
  logic [17:0] len_p3;
  logic        w_full, w_hdr, w_restart, w_end, w_mid;
  logic        hdr_bad;
  logic        mem_we, commit, drop_c, hdr_ld, cnt_inc;
  logic        drop_q;

  rdst_t       rdst, rdst_n;
  logic [31:0] sr;
  logic [2:0]  sr_cnt, ld_take;
  logic [15:0] ld_left, words_left;
  logic [15:0] hdr_len, hdr_need;
  logic [17:0] hdr_p3;
  logic        first, nb_valid;
  logic        rd_en, nb_fill, nb_load, frame_go, retire;
  logic        valid, xfer, last;

  logic [CNT_W-1:0] fc;

  assign used  = wr_ptr - rd_ptr;
  assign full  = (used == PW'(DEPTH));
  assign space = PW'(DEPTH) - used;

  assign bus.TX_BUFF_FULL  = full;
  assign bus.TX_BUFF_SPACE = space;
  assign bus.TX_BUFF_READY = (space >= PW'(MIN_SPACE))
                           && (wst == WIDLE);

  assign in_len  = bus.TX_BUFF_DATA[15:0];
  assign len_p3  = {2'b00, len} + 18'd3;
  assign need    = len_p3[17:2];
  assign wcnt_p1 = wcnt + 16'd1;

  // Mutually exclusive write events
  assign w_full    = bus.TX_BUFF_WE && full;
  assign w_restart = bus.TX_BUFF_WE && !full
                   && bus.TX_BUFF_START && (wst == WFRAME);
  assign w_hdr     = bus.TX_BUFF_WE && !full
                   && bus.TX_BUFF_START && (wst == WIDLE);
  assign w_end     = bus.TX_BUFF_WE && !full
                   && !bus.TX_BUFF_START && bus.TX_BUFF_END
                   && (wst == WFRAME);
  assign w_mid     = bus.TX_BUFF_WE && !full
                   && !bus.TX_BUFF_START && !bus.TX_BUFF_END
                   && (wst == WFRAME);

  assign hdr_bad = (in_len > MAX_L)
                 || (bus.TX_BUFF_END && (in_len != 16'd0));

  always_comb begin
    wst_n   = wst;
    mem_we  = 1'b0;
    commit  = 1'b0;
    drop_c  = 1'b0;
    hdr_ld  = 1'b0;
    cnt_inc = 1'b0;
    unique case (1'b1)
      w_full, w_restart: drop_c = 1'b1;
      w_hdr: begin
        if (hdr_bad) begin
          drop_c = 1'b1;
        end else begin
          mem_we = 1'b1;
          if (bus.TX_BUFF_END) begin
            commit = 1'b1;
          end else begin
            hdr_ld = 1'b1;
            wst_n  = WFRAME;
          end
        end
      end
      w_end: begin
        mem_we = 1'b1;
        if (wcnt_p1 == need) commit = 1'b1;
        else                 drop_c = 1'b1;
      end
      w_mid: begin
        mem_we  = 1'b1;
        cnt_inc = 1'b1;
      end
      default: ;
    endcase
    if (drop_c || commit) wst_n = WIDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wst    <= WIDLE;
      wr_ptr <= '0;
      cm_ptr <= '0;
      len    <= '0;
      wcnt   <= '0;
      drop_q <= 1'b0;
    end else begin
      wst    <= wst_n;
      drop_q <= drop_c;
      if (drop_c)      wr_ptr <= cm_ptr;
      else if (mem_we) wr_ptr <= wr_ptr + PW'(1);
      if (commit) cm_ptr <= wr_ptr + PW'(1);
      if (hdr_ld) begin
        len  <= in_len;
        wcnt <= '0;
      end else if (cnt_inc) begin
        wcnt <= wcnt_p1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[wr_ptr[ADDR_W-1:0]] <= bus.TX_BUFF_DATA;
  end

  always_ff @(posedge CLK) begin
    if (rd_en) rdq <= mem[rd_ptr[ADDR_W-1:0]];
  end

  assign hdr_len  = rdq[15:0];
  assign hdr_p3   = {2'b00, hdr_len} + 18'd3;
  assign hdr_need = hdr_p3[17:2];

  assign valid   = (sr_cnt != 3'd0);
  assign xfer    = valid && bus.TXB_READY;
  assign last    = valid && (sr_cnt == 3'd1)
                 && (ld_left == 16'd0);
  assign ld_take = (ld_left >= 16'd4) ? 3'd4 : ld_left[2:0];

  // rdq doubles as the one-word prefetch buffer
  always_comb begin
    rdst_n   = rdst;
    rd_en    = 1'b0;
    nb_fill  = 1'b0;
    nb_load  = 1'b0;
    frame_go = 1'b0;
    retire   = 1'b0;
    unique case (rdst)
      RIDLE: begin
        if (cm_ptr != rd_ptr) begin
          rd_en  = 1'b1;
          rdst_n = RHDR;
        end
      end
      RHDR: begin
        if (hdr_len == 16'd0) begin
          retire = 1'b1;
          rdst_n = RIDLE;
        end else begin
          rd_en    = 1'b1;
          frame_go = 1'b1;
          rdst_n   = RDATA;
        end
      end
      RDATA: begin
        nb_load = nb_valid && ((sr_cnt == 3'd0)
                || (xfer && (sr_cnt == 3'd1)));
        rd_en   = (words_left != 16'd0)
                && (!nb_valid || nb_load);
        nb_fill = rd_en;
        if (xfer && last) begin
          retire = 1'b1;
          rdst_n = RIDLE;
        end
      end
      default: rdst_n = RIDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdst       <= RIDLE;
      rd_ptr     <= '0;
      nb_valid   <= 1'b0;
      sr         <= '0;
      sr_cnt     <= '0;
      ld_left    <= '0;
      words_left <= '0;
      first      <= 1'b0;
    end else begin
      rdst <= rdst_n;
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      if (frame_go) begin
        ld_left    <= hdr_len;
        words_left <= hdr_need - 16'd1;
        first      <= 1'b1;
        nb_valid   <= 1'b1;
      end else begin
        if (nb_fill) words_left <= words_left - 16'd1;
        if (nb_fill)      nb_valid <= 1'b1;
        else if (nb_load) nb_valid <= 1'b0;
      end
      if (nb_load) begin
        sr      <= rdq;
        sr_cnt  <= ld_take;
        ld_left <= ld_left - {13'd0, ld_take};
      end else if (xfer) begin
        sr     <= {8'h00, sr[31:8]};
        sr_cnt <= sr_cnt - 3'd1;
      end
      if (xfer) first <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fc <= '0;
    end else if (commit != retire) begin
      fc <= commit ? fc + CNT_W'(1) : fc - CNT_W'(1);
    end
  end

  assign bus.TXB_VALID   = valid;
  assign bus.TXB_DATA    = sr[7:0];
  assign bus.TXB_FIRST   = valid && first;
  assign bus.TXB_LAST    = last;
  assign bus.FRAME_COUNT = fc;
  assign bus.DROP        = drop_q;
endmodule

// File: tb/tb_aq_gemac_tx_frame_buff.sv
// Bench for aq_gemac_tx_frame_buff: scenario tasks with
// an expected-byte queue checked against captured transfers.
`timescale 1ns/1ps
module tb_aq_gemac_tx_frame_buff;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  aq_gemac_tx_frame_buff_if #(.ADDR_W(9), .CNT_W(8)) bus ();

  aq_gemac_tx_frame_buff #(
    .ADDR_W(9), .MIN_SPACE(384), .CNT_W(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct { int t; logic [9:0] v; } obs_t;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int end_cyc = 0;
  int vrise = -1;
  int fc_peak = 0;
  int n_drop = 0;
  int n_vcyc = 0;
  int n_stall = 0;
  int n_viol = 0;
  int rdy_mode = 0;
  logic [9:0] exp_q[$];
  obs_t obs_q[$];
  logic stall_q = 1'b0;
  logic [9:0] stall_v = '0;

  always @(posedge CLK) cyc++;

  always @(posedge CLK) begin
    #1;
    if (rdy_mode == 0)      bus.TXB_READY = 1'b1;
    else if (rdy_mode == 1) bus.TXB_READY = 1'b0;
    else                    bus.TXB_READY = !bus.TXB_READY;
  end

  always @(negedge CLK) begin
    if (RST) begin
      stall_q = 1'b0;
    end else begin
      if (bus.DROP) n_drop++;
      if (bus.TXB_VALID) n_vcyc++;
      if (bus.TXB_VALID && vrise < 0) vrise = cyc;
      if (int'(bus.FRAME_COUNT) > fc_peak)
        fc_peak = int'(bus.FRAME_COUNT);
      if (stall_q && (!bus.TXB_VALID || stall_v !==
          {bus.TXB_FIRST, bus.TXB_LAST, bus.TXB_DATA}))
        n_viol++;
      stall_q = bus.TXB_VALID && !bus.TXB_READY;
      if (stall_q) n_stall++;
      stall_v = {bus.TXB_FIRST, bus.TXB_LAST, bus.TXB_DATA};
      if (bus.TXB_VALID && bus.TXB_READY)
        obs_q.push_back('{cyc, {bus.TXB_FIRST,
                        bus.TXB_LAST, bus.TXB_DATA}});
    end
  end

  task automatic wr_word(input logic s, input logic e,
                         input logic [31:0] d);
    bus.TX_BUFF_WE    = 1'b1;
    bus.TX_BUFF_START = s;
    bus.TX_BUFF_END   = e;
    bus.TX_BUFF_DATA  = d;
    if (e) end_cyc = cyc;
    @(posedge CLK); #1;
    bus.TX_BUFF_WE    = 1'b0;
    bus.TX_BUFF_START = 1'b0;
    bus.TX_BUFF_END   = 1'b0;
  endtask

  task automatic send_frame(input int len, input int nw,
                            input logic [7:0] base,
                            input logic [7:0] step);
    logic [31:0] w;
    logic [7:0] b;
    if (nw == (len + 3) / 4)
      for (int k = 0; k < len; k++) begin
        b = base + 8'(k) * step;
        exp_q.push_back({k == 0, k == len - 1, b});
      end
    wr_word(1'b1, 1'b0, 32'hBEEF_0000 | 32'(len));
    for (int i = 0; i < nw; i++) begin
      for (int j = 0; j < 4; j++) begin
        w[8*j +: 8] = (4*i + j < len)
                    ? base + 8'(4*i + j) * step : 8'hA5;
      end
      wr_word(1'b0, i == nw - 1, w);
    end
  endtask

  task automatic wait_drain(input int n, input string nm);
    int t = 0;
    while ((obs_q.size() < n || bus.FRAME_COUNT != 0)
           && t < 3000) begin
      @(posedge CLK); #1;
      t++;
    end
    n_chk++;
    if (t >= 3000)
      $display("FAIL %s_drain got %0d bytes want %0d",
               nm, obs_q.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_chk++; if (bus.TXB_VALID !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.TXB_VALID); else n_pass++;
    n_chk++; if (bus.TXB_DATA !== 8'h00) $display("FAIL rst_data got %h want 00", bus.TXB_DATA); else n_pass++;
    n_chk++; if (bus.TXB_FIRST !== 1'b0) $display("FAIL rst_first got %b want 0", bus.TXB_FIRST); else n_pass++;
    n_chk++; if (bus.TXB_LAST !== 1'b0) $display("FAIL rst_last got %b want 0", bus.TXB_LAST); else n_pass++;
    n_chk++; if (bus.FRAME_COUNT !== 8'd0) $display("FAIL rst_fc got %0d want 0", bus.FRAME_COUNT); else n_pass++;
    n_chk++; if (bus.DROP !== 1'b0) $display("FAIL rst_drop got %b want 0", bus.DROP); else n_pass++;
    n_chk++; if (bus.TX_BUFF_FULL !== 1'b0) $display("FAIL rst_full got %b want 0", bus.TX_BUFF_FULL); else n_pass++;
    n_chk++; if (bus.TX_BUFF_SPACE !== 10'd512) $display("FAIL rst_space got %0d want 512", bus.TX_BUFF_SPACE); else n_pass++;
    n_chk++; if (bus.TX_BUFF_READY !== 1'b1) $display("FAIL rst_ready got %b want 1", bus.TX_BUFF_READY); else n_pass++;
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_single();
    logic [9:0] ev;
    obs_t ob;
    int prev_t;
    int gaps = 0;
    exp_q.delete(); obs_q.delete();
    rdy_mode = 0; vrise = -1;
    send_frame(6, 2, 8'h11, 8'h11);
    n_chk++; if (bus.FRAME_COUNT !== 8'd1) $display("FAIL single_fc_up got %0d want 1", bus.FRAME_COUNT); else n_pass++;
    n_chk++; if (bus.TX_BUFF_SPACE !== 10'd509) $display("FAIL single_space got %0d want 509", bus.TX_BUFF_SPACE); else n_pass++;
    wait_drain(6, "single");
    prev_t = -1;
    while (exp_q.size() != 0) begin
      ev = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        $display("FAIL single_byte got none want %h", ev);
      end else begin
        ob = obs_q.pop_front();
        if (prev_t >= 0 && ob.t != prev_t + 1) gaps++;
        prev_t = ob.t;
        if (ob.v !== ev) $display("FAIL single_byte got %h want %h", ob.v, ev);
        else n_pass++;
      end
    end
    n_chk++; if (gaps != 0) $display("FAIL single_bubbles got %0d want 0", gaps); else n_pass++;
    n_chk++; if (vrise - end_cyc < 3 || vrise - end_cyc > 5) $display("FAIL single_latency got %0d want 3..5", vrise - end_cyc); else n_pass++;
    n_chk++; if (bus.TX_BUFF_SPACE !== 10'd512) $display("FAIL single_space_end got %0d want 512", bus.TX_BUFF_SPACE); else n_pass++;
    n_chk++; if (bus.FRAME_COUNT !== 8'd0) $display("FAIL single_fc_end got %0d want 0", bus.FRAME_COUNT); else n_pass++;
  endtask

  task automatic test_len_mismatch();
    int d0 = n_drop;
    int v0 = n_vcyc;
    exp_q.delete(); obs_q.delete();
    send_frame(5, 3, 8'h30, 8'h01);
    repeat (10) @(posedge CLK);
    #1;
    n_chk++; if (n_drop - d0 != 1) $display("FAIL mism_drop got %0d want 1", n_drop - d0); else n_pass++;
    n_chk++; if (n_vcyc - v0 != 0) $display("FAIL mism_valid got %0d want 0", n_vcyc - v0); else n_pass++;
    n_chk++; if (bus.TX_BUFF_SPACE !== 10'd512) $display("FAIL mism_space got %0d want 512", bus.TX_BUFF_SPACE); else n_pass++;
    n_chk++; if (bus.FRAME_COUNT !== 8'd0) $display("FAIL mism_fc got %0d want 0", bus.FRAME_COUNT); else n_pass++;
  endtask

  task automatic test_full();
    rdy_mode = 1;
    wr_word(1'b1, 1'b0, 32'd2044);
    for (int i = 0; i < 511; i++) wr_word(1'b0, 1'b0, 32'(i));
    n_chk++; if (bus.TX_BUFF_FULL !== 1'b1) $display("FAIL full_flag got %b want 1", bus.TX_BUFF_FULL); else n_pass++;
    n_chk++; if (bus.TX_BUFF_SPACE !== 10'd0) $display("FAIL full_space got %0d want 0", bus.TX_BUFF_SPACE); else n_pass++;
    n_chk++; if (bus.TX_BUFF_READY !== 1'b0) $display("FAIL full_ready got %b want 0", bus.TX_BUFF_READY); else n_pass++;
    wr_word(1'b0, 1'b0, 32'hDEAD_BEEF);
    n_chk++; if (bus.DROP !== 1'b1) $display("FAIL full_drop got %b want 1", bus.DROP); else n_pass++;
    n_chk++; if (bus.TX_BUFF_SPACE !== 10'd512) $display("FAIL full_space_back got %0d want 512", bus.TX_BUFF_SPACE); else n_pass++;
    n_chk++; if (bus.TX_BUFF_FULL !== 1'b0) $display("FAIL full_clear got %b want 0", bus.TX_BUFF_FULL); else n_pass++;
    @(posedge CLK); #1;
    n_chk++; if (bus.DROP !== 1'b0) $display("FAIL full_drop_pulse got %b want 0", bus.DROP); else n_pass++;
    rdy_mode = 0;
  endtask

  task automatic test_back_to_back();
    logic [9:0] ev;
    obs_t ob;
    int lasts = 0;
    int v0 = n_viol;
    int s0 = n_stall;
    exp_q.delete(); obs_q.delete();
    fc_peak = 0;
    rdy_mode = 2;
    send_frame(4, 1, 8'hA0, 8'h01);
    send_frame(1, 1, 8'hC7, 8'h01);
    wait_drain(5, "b2b");
    while (exp_q.size() != 0) begin
      ev = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        $display("FAIL b2b_byte got none want %h", ev);
      end else begin
        ob = obs_q.pop_front();
        if (ob.v[8]) lasts++;
        if (ob.v !== ev) $display("FAIL b2b_byte got %h want %h", ob.v, ev);
        else n_pass++;
      end
    end
    n_chk++; if (obs_q.size() != 0) $display("FAIL b2b_extra got %0d want 0", obs_q.size()); else n_pass++;
    n_chk++; if (lasts != 2) $display("FAIL b2b_lasts got %0d want 2", lasts); else n_pass++;
    n_chk++; if (n_stall - s0 == 0) $display("FAIL b2b_stalls got 0 want >0"); else n_pass++;
    n_chk++; if (n_viol - v0 != 0) $display("FAIL b2b_hold got %0d want 0", n_viol - v0); else n_pass++;
    n_chk++; if (fc_peak != 2) $display("FAIL b2b_fc_peak got %0d want 2", fc_peak); else n_pass++;
    rdy_mode = 0;
  endtask

  task automatic test_hdr_only();
    int v0 = n_vcyc;
    int d0 = n_drop;
    wr_word(1'b1, 1'b1, 32'hBEEF_0000);
    n_chk++; if (bus.FRAME_COUNT !== 8'd1) $display("FAIL hdr0_fc_up got %0d want 1", bus.FRAME_COUNT); else n_pass++;
    repeat (6) @(posedge CLK);
    #1;
    n_chk++; if (bus.FRAME_COUNT !== 8'd0) $display("FAIL hdr0_fc_down got %0d want 0", bus.FRAME_COUNT); else n_pass++;
    n_chk++; if (n_vcyc - v0 != 0) $display("FAIL hdr0_valid got %0d want 0", n_vcyc - v0); else n_pass++;
    n_chk++; if (n_drop - d0 != 0) $display("FAIL hdr0_drop got %0d want 0", n_drop - d0); else n_pass++;
    n_chk++; if (bus.TX_BUFF_SPACE !== 10'd512) $display("FAIL hdr0_space got %0d want 512", bus.TX_BUFF_SPACE); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [9:0] ev;
    obs_t ob;
    int t = 0;
    exp_q.delete(); obs_q.delete();
    rdy_mode = 0;
    send_frame(8, 2, 8'h50, 8'h03);
    while (obs_q.size() < 2 && t < 100) begin
      @(posedge CLK); #1;
      t++;
    end
    n_chk++; if (t >= 100) $display("FAIL rmid_start got %0d bytes want 2", obs_q.size()); else n_pass++;
    ev = exp_q.pop_front();
    n_chk++;
    if (obs_q.size() == 0) $display("FAIL rmid_byte0 got none want %h", ev);
    else begin
      ob = obs_q.pop_front();
      if (ob.v !== ev) $display("FAIL rmid_byte0 got %h want %h", ob.v, ev);
      else n_pass++;
    end
    RST = 1'b1;
    #1;
    n_chk++; if (bus.TXB_VALID !== 1'b0) $display("FAIL rmid_valid got %b want 0", bus.TXB_VALID); else n_pass++;
    n_chk++; if (bus.TX_BUFF_SPACE !== 10'd512) $display("FAIL rmid_space got %0d want 512", bus.TX_BUFF_SPACE); else n_pass++;
    n_chk++; if (bus.FRAME_COUNT !== 8'd0) $display("FAIL rmid_fc got %0d want 0", bus.FRAME_COUNT); else n_pass++;
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_q.delete(); obs_q.delete();
    @(posedge CLK); #1;
    send_frame(3, 1, 8'h90, 8'h07);
    wait_drain(3, "rmid");
    while (exp_q.size() != 0) begin
      ev = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        $display("FAIL rmid_after got none want %h", ev);
      end else begin
        ob = obs_q.pop_front();
        if (ob.v !== ev) $display("FAIL rmid_after got %h want %h", ob.v, ev);
        else n_pass++;
      end
    end
    n_chk++; if (obs_q.size() != 0) $display("FAIL rmid_extra got %0d want 0", obs_q.size()); else n_pass++;
  endtask

  initial begin
    bus.TX_BUFF_WE    = 1'b0;
    bus.TX_BUFF_START = 1'b0;
    bus.TX_BUFF_END   = 1'b0;
    bus.TX_BUFF_DATA  = '0;
    test_reset();
    test_single();
    test_len_mismatch();
    test_full();
    test_back_to_back();
    test_hdr_only();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
